// File: rtl/image_frame_buffer.sv
// image_frame_buffer
// Ping-pong image store between the pixel receive stream and the inference
// core. One bank fills from the valid/ready stream while the other holds the
// last completed frame for random-access reads. Every pixel is binarised
// against the threshold as it is written, so the packed bit-image of a frame
// is available the same cycle the frame is handed off.
module image_frame_buffer #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = 8,
    localparam int NUM_PIX = IMG_W * IMG_H,
    localparam int ADDR_W  = $clog2(NUM_PIX)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [PIX_W-1:0]   s_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [PIX_W-1:0]   threshold,
    output logic               frame_valid,
    input  logic               frame_consume,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [PIX_W-1:0]   rd_data,
    output logic [NUM_PIX-1:0] bin_image,
    output logic [ADDR_W:0]    fill_count
);

    localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(NUM_PIX - 1);
    localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(NUM_PIX);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

    // FILL accepts pixels; STALL holds a complete fill bank until the
    // consumer releases the ready bank.
    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t state, next_state;

    // fill_sel names the bank being written; the other bank is the ready bank.
    logic fill_sel;

    logic [PIX_W-1:0]   bank0 [NUM_PIX];
    logic [PIX_W-1:0]   bank1 [NUM_PIX];
    logic [NUM_PIX-1:0] bits0;
    logic [NUM_PIX-1:0] bits1;

    logic              accept;
    logic              last_pix;
    logic              stall_release;
    logic              swap;
    logic [ADDR_W-1:0] wr_addr;

    // Handshake and hand-off decode shared by the FSM and the datapath.
    // NOTE: every signal written in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        accept        = s_valid && s_ready;
        last_pix      = accept && (fill_count == LAST_IDX);
        stall_release = (state == STALL) && frame_consume && !clear;
        swap          = (last_pix && (!frame_valid || frame_consume)) || stall_release;
        wr_addr       = fill_count[ADDR_W-1:0];
    end

    // Write FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    // Write FSM next-state: stall on a completed fill the consumer still blocks.
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = FILL;
        end else if (last_pix && !swap) begin
            next_state = STALL;
        end else if (stall_release) begin
            next_state = FILL;
        end
    end

    // Write FSM outputs: ready only while filling, never during clear or reset.
    always_comb begin
        s_ready = (state == FILL) && !clear && !reset;
    end

    // Fill counter, bank select and ready-frame flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_count  <= '0;
            fill_sel    <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            if (clear || swap) begin
                fill_count <= '0;
            end else if (accept) begin
                fill_count <= fill_count + CNT_ONE;
            end

            if (swap) begin
                fill_sel <= !fill_sel;
            end

            if (swap) begin
                frame_valid <= 1'b1;
            end else if (frame_consume) begin
                frame_valid <= 1'b0;
            end
        end
    end

    // Pixel and binarised-bit writes into the fill bank.
    // NOTE: the banks are deliberately not reset; frame_valid and fill_count
    // gate everything that could expose stale contents, and leaving the reset
    // off lets the pixel store map onto RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (fill_sel) begin
                bank1[wr_addr] <= s_data;
                bits1[wr_addr] <= (s_data >= threshold);
            end else begin
                bank0[wr_addr] <= s_data;
                bits0[wr_addr] <= (s_data >= threshold);
            end
        end
    end

    // Registered read port on the ready bank; zero when out of range or empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (frame_valid && ({1'b0, rd_addr} < FULL_CNT)) begin
            rd_data <= fill_sel ? bank0[rd_addr] : bank1[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

    // Packed bit-image of the ready bank, hidden while no frame is held.
    always_comb begin
        bin_image = '0;
        if (frame_valid) begin
            bin_image = fill_sel ? bits0 : bits1;
        end
    end

endmodule
